// File: rtl/lsu_mem_if.sv
// Load/store memory interface: one request at a time, bus address/data handshake,
// store strobe/lane replication, load right-justification, and a bus wait timeout.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic               mem_valid_q, mem_valid_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_mis_q, rsp_mis_d;
    logic               rsp_to_q, rsp_to_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;

    logic [1:0]         req_size_n;
    logic               req_mis;
    logic [31:0]        rd_mask;
    logic               cnt_expired;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= 2'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_mis_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            off_q       <= off_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_to_q    <= rsp_to_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, request capture and registered-output next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_to_d    = rsp_to_q;

        req_size_n  = (req_size == 2'd3) ? 2'd2 : req_size;
        req_mis     = ((req_size_n == 2'd1) && req_addr[0]) ||
                      ((req_size_n == 2'd2) && (req_addr[1:0] != 2'b00));
        cnt_expired = ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

        case (size_q)
            2'd0:    rd_mask = 32'h0000_00FF;
            2'd1:    rd_mask = 32'h0000_FFFF;
            default: rd_mask = 32'hFFFF_FFFF;
        endcase

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    size_d    = req_size_n;
                    off_d     = req_addr[1:0];
                    rsp_mis_d = 1'b0;
                    rsp_to_d  = 1'b0;
                    if (req_mis) begin
                        state_d     = S_RESP;
                        rsp_mis_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d    = S_ADDR;
                        cnt_d      = '0;
                        mem_we_d   = req_we;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we) begin
                            case (req_size_n)
                                2'd0: begin
                                    mem_wstrb_d = 4'b0001 << req_addr[1:0];
                                    mem_wdata_d = {4{req_wdata[7:0]}};
                                end
                                2'd1: begin
                                    mem_wstrb_d = 4'b0011 << req_addr[1:0];
                                    mem_wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_wstrb_d = 4'b1111;
                                    mem_wdata_d = req_wdata;
                                end
                            endcase
                        end else begin
                            mem_wstrb_d = 4'b0000;
                            mem_wdata_d = '0;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d     = S_RESP;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if (cnt_expired) begin
                    state_d     = S_RESP;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = (mem_rdata >> {off_q, 3'b000}) & rd_mask;
                end else if (cnt_expired) begin
                    state_d     = S_RESP;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus outputs are only meaningful during the address phase
        mem_valid_d = (state_d == S_ADDR);
        if (state_d != S_ADDR) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wstrb_d = '0;
            mem_wdata_d = '0;
        end
        rsp_valid_d = (state_d == S_RESP);
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign req_ready      = req_ready_q;
    assign busy           = busy_q;
    assign mem_valid      = mem_valid_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign mem_wdata      = mem_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;
    assign rsp_timeout    = rsp_to_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Randomized transaction-level bench for lsu_mem_if with a short timeout.
module tb_lsu_mem_if;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_rdata;
    logic        last_mis;
    logic        last_to;

    lsu_mem_if #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
        check_eq({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check_eq({tag, "_rsp_mis"}, 32'(rsp_misaligned), 32'd0);
        check_eq({tag, "_rsp_to"}, 32'(rsp_timeout), 32'd0);
    endtask

    // One request end to end. dr/dv: bus wait cycles before mem_ready / mem_rvalid
    // (values >= T mean the bus never answers inside the window).
    task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int dr, input int dv);
        int          nb, off, x, y, e;
        logic        mis, to_a, to_v, to, in_addr, in_rdata;
        logic [3:0]  es;
        logic [31:0] ew, er, mask;
        logic [31:0] exp_rd;

        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = (off % nb) != 0;
        for (int b = 0; b < 4; b++) begin
            es[b]          = we && (b >= off) && (b < off + nb);
            ew[8*b +: 8]   = we ? wdata[8*(b % nb) +: 8] : 8'h00;
        end
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        er   = (rdata >> (8 * off)) & mask;

        to_a = (dr >= int'(T));
        x    = to_a ? int'(T) : 1 + dr;
        to_v = (dv >= int'(T));
        y    = to_v ? x + int'(T) : x + 1 + dv;
        if (mis)             e = 0;
        else if (we || to_a) e = x;
        else                 e = y;
        to     = !mis && (to_a || (!we && to_v));
        exp_rd = (!we && !mis && !to) ? er : 32'h0;

        @(negedge clk);
        check_eq("pre_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;

        for (int i = 1; i <= e + 2; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            in_addr   = !mis && (i <= x);
            in_rdata  = !mis && !we && !to_a && (i > x) && (i <= y);

            check_eq("mem_valid", 32'(mem_valid), 32'(in_addr));
            if (in_addr) begin
                check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
                check_eq("mem_we", 32'(mem_we), 32'(we));
                check_eq("mem_wstrb", 32'(mem_wstrb), 32'(es));
                check_eq("mem_wdata", mem_wdata, ew);
            end
            check_eq("rsp_valid", 32'(rsp_valid), 32'(i == e + 1));
            check_eq("busy", 32'(busy), 32'(i <= e + 1));
            if (i == e + 1) begin
                last_rdata = exp_rd;
                last_mis   = mis;
                last_to    = to;
            end
            if (i <= e) begin
                check_eq("rsp_rdata_hold", rsp_rdata, last_rdata);
                check_eq("rsp_mis_clr", 32'(rsp_misaligned), 32'd0);
                check_eq("rsp_to_clr", 32'(rsp_timeout), 32'd0);
            end else begin
                check_eq("rsp_rdata", rsp_rdata, last_rdata);
                check_eq("rsp_mis", 32'(rsp_misaligned), 32'(last_mis));
                check_eq("rsp_to", 32'(rsp_timeout), 32'(last_to));
            end
            if (i == e + 2) check_eq("idle_req_ready", 32'(req_ready), 32'd1);

            mem_ready  = in_addr ? (i == 1 + dr) : 1'($urandom_range(0, 1));
            mem_rvalid = in_rdata ? (i == x + 1 + dv) : 1'($urandom_range(0, 1));
            mem_rdata  = (in_rdata && (i == x + 1 + dv)) ? rdata : $urandom;
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 1)) : int'($urandom_range(0, 1));
    endfunction

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'd0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        last_rdata = '0;
        last_mis   = 1'b0;
        last_to    = 1'b0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_txn(1'b0, 2'd0, 32'h0000_1003, 32'h0, 32'hA1B2_C3D4, 0, 0);
        run_txn(1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0);
        run_txn(1'b0, 2'd2, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, 0);
        run_txn(1'b1, 2'd0, 32'h0000_4001, 32'h0000_005A, 32'h0, 3, 0);
        run_txn(1'b0, 2'd2, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 0, 99);
        run_txn(1'b1, 2'd2, 32'h0000_6000, 32'hCAFE_F00D, 32'h0, 99, 0);
        run_txn(1'b0, 2'd1, 32'h0000_7002, 32'h0, 32'h8765_4321, 1, T - 1);
        run_txn(1'b0, 2'd3, 32'h0000_8000, 32'h0, 32'h0BAD_F00D, T - 1, 2);

        // Reset asserted while waiting for read data
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        check_eq("rst_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset_n    = 1'b1;
        last_rdata = '0;
        last_mis   = 1'b0;
        last_to    = 1'b0;
        run_txn(1'b0, 2'd0, 32'h0000_0042, 32'h0, 32'h00C3_0000, 0, 0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                    $urandom, $urandom, rand_wait(), rand_wait());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store memory interface between the execute stage and the data-memory bus. It accepts one load or store request at a time and runs the bus address/data handshake. For stores it generates byte strobes and lane-replicated write data. For loads it right-justifies the addressed byte or halfword before handing the word to the register-mask stage, which then zero- or sign-extends it.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting in ADDR or RDATA before the request is aborted with an error; must be ≥1.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_valid  out  1  bus address phase valid
- mem_ready  in  1  bus accepts the address phase
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address, {req_addr[31:2], 2'b00}
- mem_wstrb  out  4  byte strobes (stores only, 0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load data shifted to bit 0, zero above the access size; 0 for stores and errors
- rsp_misaligned  out  1  request was misaligned; qualified by rsp_valid
- rsp_timeout  out  1  bus timeout; qualified by rsp_valid
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ADDR, RDATA, RESP.
- IDLE: req_ready=1. When req_valid=1, capture we, size, addr and wdata.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]≠0): go to RESP with misaligned=1. No bus activity.
  - Otherwise go to ADDR.
- ADDR: mem_valid=1, with mem_we/mem_addr/mem_wstrb/mem_wdata held from the captured request.
  - mem_ready=1 and store: go to RESP.
  - mem_ready=1 and load: go to RDATA.
- RDATA: wait for mem_rvalid=1. Capture mem_rdata shifted right by 8·addr[1:0], masked to the access size, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Wait counter: cleared on entry to ADDR and to RDATA, incremented each cycle spent waiting. When it reaches TIMEOUT_CYCLES, go to RESP with timeout=1 and rsp_rdata=0. mem_valid drops on that exit.
- Strobes: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<addr[1:0]; word → 4'b1111.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- mem_rvalid is ignored outside RDATA, including a same-cycle mem_ready+mem_rvalid in ADDR. mem_ready is ignored outside ADDR.
- rsp_rdata, rsp_misaligned and rsp_timeout hold their values until the next RESP. The flags are cleared on request accept.

## Timing
- Reset values: state IDLE; req_ready=1, busy=0; mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_timeout=0.
- Cycle numbering: cycle 0 is the accept edge.
  - Misaligned: rsp_valid in cycle 1.
  - Store with mem_ready in cycle 1: rsp_valid in cycle 2.
  - Load with mem_ready in cycle 1 and mem_rvalid in cycle 2: rsp_valid in cycle 3.
  - Each extra wait cycle adds exactly one cycle of latency.
- Back-to-back: the next request can be accepted in the cycle after RESP.
- Reset asserted mid-transaction: return to IDLE immediately and drop mem_valid asynchronously. No rsp_valid is produced for the aborted request.

## Test plan
- Load byte, addr=0x1003, mem_rdata=0xA1B2C3D4 → mem_addr=0x1000, wstrb=0, rsp_rdata=0x000000A1, rsp_valid 3 cycles after accept.
- Store half, addr=0x2002, wdata=0x0000BEEF → mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1, rsp_valid in cycle 2.
- Word load at addr=0x3001 → no mem_valid ever, rsp_valid in cycle 1 with rsp_misaligned=1, rsp_rdata=0.
- Store byte with mem_ready held low for 3 cycles → mem_valid stays high and all bus outputs stay stable; rsp_valid arrives 3 cycles later than the zero-wait case.
- TIMEOUT_CYCLES=4, load with mem_rvalid never asserted → rsp_valid with rsp_timeout=1, rsp_rdata=0; an mem_rvalid afterwards is ignored.
- reset_n pulsed low while in RDATA → all outputs return to reset values; the next request completes normally.
